// File: rtl/poly_token_issuer.sv
// Host-side issuer: streams a request's data tokens into the data FIFO, then its command token.
// Optional ISSUER_STATS_EN build adds command/data write counters on cmd_count/tok_count.
module poly_token_issuer #(
    parameter int word_size = 16,
    parameter int max_deg   = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [7:0]           req_op,
    input  logic [2:0]           req_a,
    input  logic [4:0]           req_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [word_size-1:0] in_data,
    input  logic                 data_full,
    output logic                 wr_data_fifo,
    output logic [word_size-1:0] data_out,
    input  logic                 cmd_full,
    output logic                 wr_cmd_fifo,
    output logic [word_size-1:0] cmd_out,
    output logic                 done,
    output logic                 err,
    output logic                 busy,
    output logic [15:0]          cmd_count,
    output logic [15:0]          tok_count
);
    typedef enum logic [1:0] {IDLE, DATA, CMD, DONE} state_t;

    state_t               state;
    logic [5:0]           cnt;
    logic                 err_q;
    logic [word_size-1:0] cmd_q;

    logic [5:0] req_cnt;
    logic       req_bad;
    logic [4:0] arg2;

    // Decode token count and legality of the request on the input side.
    always_comb begin
        req_cnt = '0;
        req_bad = 1'b0;
        arg2    = '0;
        case (req_op)
            8'd0: begin
                req_cnt = {1'b0, req_n} + 6'd1;
                arg2    = req_n;
                req_bad = int'(req_n) > max_deg;
            end
            8'd1: req_cnt = 6'd1;
            8'd2: begin
                req_cnt = {1'b0, req_n};
                arg2    = req_n;
                req_bad = (req_n == 5'd0);
            end
            8'd3: req_cnt = 6'd0;
            default: req_bad = 1'b1;
        endcase
    end

    assign req_ready    = (state == IDLE);
    assign in_ready     = (state == DATA) && !data_full;
    assign wr_data_fifo = (state == DATA) && in_valid && !data_full;
    assign data_out     = in_data;
    assign wr_cmd_fifo  = (state == CMD) && !cmd_full;
    assign cmd_out      = cmd_q;
    assign done         = (state == DONE);
    assign err          = (state == DONE) && err_q;
    assign busy         = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            err_q <= 1'b0;
            cmd_q <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    cmd_q <= word_size'({arg2, req_a, req_op});
                    err_q <= req_bad;
                    cnt   <= req_bad ? 6'd0 : req_cnt;
                    if (req_bad)             state <= DONE;
                    else if (req_cnt == 6'd0) state <= CMD;
                    else                      state <= DATA;
                end
                DATA: if (wr_data_fifo) begin
                    cnt <= cnt - 6'd1;
                    if (cnt == 6'd1) state <= CMD;
                end
                CMD: if (wr_cmd_fifo) state <= DONE;
                DONE: begin
                    err_q <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ISSUER_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_count <= '0;
            tok_count <= '0;
        end else begin
            if (wr_cmd_fifo)  cmd_count <= cmd_count + 16'd1;
            if (wr_data_fifo) tok_count <= tok_count + 16'd1;
        end
    end
`else
    assign cmd_count = '0;
    assign tok_count = '0;
`endif

endmodule

// File: tb/tb_poly_token_issuer.sv
// Randomized + directed scoreboard bench for poly_token_issuer.
module tb_poly_token_issuer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0, req_ready;
    logic [7:0]  req_op = '0;
    logic [2:0]  req_a = '0;
    logic [4:0]  req_n = '0;
    logic        in_valid = 1'b0, in_ready;
    logic [15:0] in_data = '0;
    logic        data_full = 1'b0, wr_data_fifo;
    logic [15:0] data_out;
    logic        cmd_full = 1'b0, wr_cmd_fifo;
    logic [15:0] cmd_out;
    logic        done, err, busy;
    logic [15:0] cmd_count, tok_count;

    always #5 clk = ~clk;

    poly_token_issuer dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_n(req_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .data_full(data_full), .wr_data_fifo(wr_data_fifo), .data_out(data_out),
        .cmd_full(cmd_full), .wr_cmd_fifo(wr_cmd_fifo), .cmd_out(cmd_out),
        .done(done), .err(err), .busy(busy),
        .cmd_count(cmd_count), .tok_count(tok_count)
    );

    // kind: 0 data write, 1 command write, 2 done (val = err)
    typedef struct { int kind; logic [15:0] val; } ev_t;
    ev_t         exp_q[$];
    ev_t         ev;
    int          checks = 0, errors = 0;
    int          exp_cmds = 0, exp_toks = 0;
    logic [15:0] dbuf [40];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic take(input int kind, input logic [15:0] act, input string name);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected event actual=%h required=none", name, act);
        end else begin
            ev = exp_q.pop_front();
            if (ev.kind != kind || ev.val !== act) begin
                errors++;
                $display("FAIL %s actual=kind%0d/%h required=kind%0d/%h", name, kind, act, ev.kind, ev.val);
            end
        end
    endtask

    // Monitor: every FIFO write / done is matched against the scoreboard in order.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            if (wr_data_fifo) begin
                chk("write_while_data_full", {63'd0, data_full}, 64'd0);
                take(0, data_out, "data_write");
            end
            if (wr_cmd_fifo) begin
                chk("write_while_cmd_full", {63'd0, cmd_full}, 64'd0);
                take(1, cmd_out, "cmd_write");
            end
            if (done) take(2, {15'd0, err}, "done_err");
        end
    end

    // Reference: push the response a request should produce, straight from the op rules.
    task automatic model(input logic [7:0] op, input logic [2:0] a, input logic [4:0] n);
        int ntok; bit bad; logic [4:0] arg2; ev_t e;
        bad = 0; arg2 = 0; ntok = 0;
        if (op == 0)      begin ntok = n + 1; arg2 = n; bad = (n > 10); end
        else if (op == 1) ntok = 1;
        else if (op == 2) begin ntok = n; arg2 = n; bad = (n == 0); end
        else if (op == 3) ntok = 0;
        else              bad = 1;
        if (!bad) begin
            for (int i = 0; i < ntok; i++) begin e.kind = 0; e.val = dbuf[i]; exp_q.push_back(e); end
            e.kind = 1; e.val = {arg2, a, op}; exp_q.push_back(e);
            exp_toks += ntok; exp_cmds += 1;
        end
        e.kind = 2; e.val = {15'd0, bad}; exp_q.push_back(e);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 40; i++) dbuf[i] = 16'($urandom);
    endtask

    task automatic chk_stats(input string tag);
`ifdef ISSUER_STATS_EN
        chk({tag, "_cmd_count"}, {48'd0, cmd_count}, {48'd0, 16'(exp_cmds)});
        chk({tag, "_tok_count"}, {48'd0, tok_count}, {48'd0, 16'(exp_toks)});
`else
        chk({tag, "_cmd_count"}, {48'd0, cmd_count}, 64'd0);
        chk({tag, "_tok_count"}, {48'd0, tok_count}, 64'd0);
`endif
    endtask

    task automatic run_req(input logic [7:0] op, input logic [2:0] a, input logic [4:0] n, input bit rnd,
                           input int df_from, input int df_len, input int cf_from, input int cf_len,
                           input int exp_lat);
        int idx, lat; bit seen_done, finished;
        idx = 0; lat = 0; seen_done = 0; finished = 0;
        model(op, a, n);
        @(posedge clk); #1;
        req_valid = 1; req_op = op; req_a = a; req_n = n;
        in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0; in_data = dbuf[0];
        data_full = 0; cmd_full = 0;
        @(negedge clk);
        chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
        for (int k = 1; k < 3000 && !finished; k++) begin
            @(posedge clk); #1;
            if (rnd && !seen_done) begin
                req_valid = 1'($urandom_range(0, 1));
                req_op = 8'($urandom); req_a = 3'($urandom); req_n = 5'($urandom);
            end else req_valid = 0;
            in_data   = dbuf[idx < 40 ? idx : 39];
            in_valid  = rnd ? ($urandom_range(0, 9) < 7) : 1'b1;
            data_full = rnd ? ($urandom_range(0, 3) == 0) : (k >= df_from && k < df_from + df_len);
            cmd_full  = rnd ? ($urandom_range(0, 3) == 0) : (k >= cf_from && k < cf_from + cf_len);
            @(negedge clk);
            if (done && !seen_done) begin seen_done = 1; lat = k; end
            if (in_valid && in_ready) idx++;
            if (!busy) finished = 1;
        end
        if (!finished || !seen_done) begin
            checks++; errors++;
            $display("FAIL request_timeout actual=not_done required=done op=%0d", op);
        end
        if (exp_lat != 0) chk("done_latency", 64'(lat), 64'(exp_lat));
        req_valid = 0; in_valid = 0; data_full = 0; cmd_full = 0;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        chk_stats("stats");
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk("reset_ready_busy_done_err", {60'd0, req_ready, busy, done, err}, 64'h8);
        chk("reset_writes_inready", {61'd0, wr_data_fifo, wr_cmd_fifo, in_ready}, 64'd0);
        chk("reset_cmd_out", {48'd0, cmd_out}, 64'd0);
        chk("reset_counts", {32'd0, cmd_count, tok_count}, 64'd0);
        @(posedge clk); #1 rst = 1;

        // STP A=2 N=3, coeffs 5..8
        fill_rand(); dbuf[0] = 16'd5; dbuf[1] = 16'd6; dbuf[2] = 16'd7; dbuf[3] = 16'd8;
        run_req(8'd0, 3'd2, 5'd3, 0, 0, 0, 0, 0, 6);
        // EVB A=1 b=2, data_full 5 cycles after the first token
        fill_rand(); run_req(8'd2, 3'd1, 5'd2, 0, 2, 5, 0, 0, 9);
        // RST: command only
        fill_rand(); run_req(8'd3, 3'd0, 5'd0, 0, 0, 0, 0, 0, 2);
        // Illegal requests, then a normal EVP
        fill_rand(); run_req(8'd7, 3'd0, 5'd0, 0, 0, 0, 0, 0, 1);
        fill_rand(); run_req(8'd0, 3'd4, 5'd12, 0, 0, 0, 0, 0, 1);
        fill_rand(); run_req(8'd2, 3'd5, 5'd0, 0, 0, 0, 0, 0, 1);
        fill_rand(); run_req(8'd1, 3'd3, 5'd9, 0, 0, 0, 0, 0, 3);
        // EVP with cmd_full held 10 cycles
        fill_rand(); run_req(8'd1, 3'd6, 5'd0, 0, 0, 0, 1, 10, 12);
        // Largest EVB: 31 data tokens; STP at max degree
        fill_rand(); run_req(8'd2, 3'd7, 5'd31, 0, 0, 0, 0, 0, 33);
        fill_rand(); run_req(8'd0, 3'd1, 5'd10, 0, 0, 0, 0, 0, 13);

        // Reset after 2 of 4 STP tokens: those two stay written, no command follows
        begin
            ev_t e; int idx;
            fill_rand(); idx = 0;
            for (int i = 0; i < 2; i++) begin e.kind = 0; e.val = dbuf[i]; exp_q.push_back(e); end
            @(posedge clk); #1;
            req_valid = 1; req_op = 8'd0; req_a = 3'd2; req_n = 5'd3;
            for (int k = 0; k < 50 && idx < 2; k++) begin
                @(negedge clk);
                if (in_valid && in_ready) idx++;
                @(posedge clk); #1;
                req_valid = 0; in_valid = 1; in_data = dbuf[idx < 40 ? idx : 39];
            end
            in_valid = 0; rst = 0;
            @(negedge clk);
            chk("midreset_busy_wrcmd", {62'd0, busy, wr_cmd_fifo}, 64'd0);
            chk("midreset_counts", {32'd0, cmd_count, tok_count}, 64'd0);
            chk("midreset_data_written", 64'(idx), 64'd2);
            exp_cmds = 0; exp_toks = 0;
            @(posedge clk); @(posedge clk); #1 rst = 1;
            @(negedge clk);
            chk("midreset_scoreboard", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        fill_rand(); run_req(8'd1, 3'd2, 5'd0, 0, 0, 0, 0, 0, 3);

        // Randomized requests with random stalls and stray req_valid / in_valid
        for (int r = 0; r < 60; r++) begin
            logic [7:0] op; logic [4:0] n;
            op = 8'($urandom_range(0, 4));
            if (op == 8'd4) op = 8'($urandom_range(4, 255));
            n = (op == 8'd0) ? 5'($urandom_range(0, 12)) : 5'($urandom);
            fill_rand();
            run_req(op, 3'($urandom), n, 1, 0, 0, 0, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
